nn_grad_sng: RTL and testbench
==============================

# nn_grad_sng

Signed stochastic gradient generator that sits directly upstream of the smooth-gradient parameter accumulator. It accepts one signed binary gradient word per training step over a valid/ready handshake. It then emits a fixed-length unipolar stochastic bitstream (`SS_OUT`) with a constant sign line (`SIGN_OUT`) and an enable strobe (`EN_OUT`) that drive the accumulator's stochastic input, sign input and enable input. Over one full stream, the number of 1 bits equals the gradient magnitude exactly.

## Interface
- `N`, 8: gradient magnitude width and LFSR width.
- `STREAM_LEN`, 2^N-1: bits per stream. Legal range is 1 to 2^N-1.
- `SEED`, 1: LFSR load value. Must be nonzero.

- `CLK` input, 1 bit: the single clock.
- `INITn` input, 1 bit: reset, synchronous and active-low.
- `GRAD_MAG` input, N bits: unsigned gradient magnitude.
- `GRAD_SIGN` input, 1 bit: 1 means negative.
- `GRAD_VALID` input, 1 bit: gradient word offered.
- `GRAD_READY` output, 1 bit: block can accept a word.
- `PAUSE` input, 1 bit: freezes streaming (driven by the training-clock gate).
- `SS_OUT` output, 1 bit: stochastic bit to the accumulator.
- `SIGN_OUT` output, 1 bit: sign of the current stream.
- `EN_OUT` output, 1 bit: marks `SS_OUT` as valid for the accumulator.
- `DONE` output, 1 bit: one-cycle pulse after the final bit of a stream.

## Operation
- FSM states are IDLE, STREAM and DONE. The reset state is IDLE.
- Reset values while `INITn`=0:
  - `SS_OUT`=0, `SIGN_OUT`=0, `EN_OUT`=0, `DONE`=0, `GRAD_READY`=0.
  - Internal registers: `lfsr`=`SEED`, `cnt`=0, `mag_reg`=0.
- `GRAD_READY` = (state==IDLE) & `INITn`. It is decoded from the state, with no registered delay.
- IDLE, when `GRAD_VALID` & `GRAD_READY`:
  - Load `mag_reg`←`GRAD_MAG`, `SIGN_OUT`←`GRAD_SIGN`, `lfsr`←`SEED`, `cnt`←0.
  - Go to STREAM.
  - `GRAD_VALID` without ready is ignored. The word is not latched.
- STREAM, with `PAUSE`=0, on each edge:
  - `SS_OUT`←(`lfsr` ≤ `mag_reg`), `EN_OUT`←1.
  - `lfsr` advances one Fibonacci step and `cnt`←`cnt`+1.
  - When `cnt`==`STREAM_LEN`-1, go to DONE.
- STREAM, with `PAUSE`=1:
  - `SS_OUT`←0 and `EN_OUT`←0.
  - `lfsr`, `cnt` and `SIGN_OUT` hold.
  - No bits are lost or duplicated across a pause.
- DONE:
  - `SS_OUT`←0, `EN_OUT`←0, `DONE`←1 for exactly one cycle.
  - Next state is IDLE.
  - `SIGN_OUT` holds until the next accepted word.
- Arithmetic rules:
  - The comparison is unsigned N-bit.
  - The LFSR is maximal length and visits 1 to 2^N-1, never 0.
  - With `STREAM_LEN`=2^N-1, the count of 1s equals `mag_reg` exactly: 0 gives all-zero, 2^N-1 gives all-one.
- `cnt` width is clog2(`STREAM_LEN`+1). `cnt` never wraps inside a stream.
- Reset mid-stream takes effect on the next edge. All outputs return to reset values and no DONE pulse is issued.
- `GRAD_MAG` and `GRAD_SIGN` changes outside the accept cycle have no effect.

## Timing
- Accept edge t. The first valid `SS_OUT`/`EN_OUT` is visible after edge t+1.
- With no pause, the last bit is visible after edge t+`STREAM_LEN`.
- `DONE`=1 after edge t+`STREAM_LEN`+1, and `GRAD_READY`=1 from that same cycle.
- The next accept is therefore possible at edge t+`STREAM_LEN`+2.
- Each `PAUSE` cycle in STREAM delays everything above by one cycle.
- All outputs are registered except `GRAD_READY`.

## Structure
- Shared package `nn_sng_pkg`:
  - FSM state enum.
  - Maximal-length LFSR tap constants indexed by width. For N=8 the polynomial is x^8+x^6+x^5+x^4+1.
  - A function that computes the next LFSR state.
- One natural sub-module, `nn_lfsr`, with width and taps as parameters and load, step and seed inputs. The same LFSR is reused by the other stochastic number generators.

## Test plan
- After reset release, load `GRAD_MAG`=0x40, `GRAD_SIGN`=0, N=8, `STREAM_LEN`=255 → exactly 64 cycles with `SS_OUT`=1 & `EN_OUT`=1, 255 `EN_OUT` cycles in total, `SIGN_OUT`=0, `DONE` pulse at accept+256.
- `GRAD_MAG`=0x00, then a second run with `GRAD_MAG`=0xFF, sign 1 → first run has 0 ones; second run has 255 ones with `SIGN_OUT`=1 throughout.
- `GRAD_MAG`=0x80 with `PAUSE` high for 10 cycles mid-stream → `EN_OUT` low during the pause, still 128 ones over 255 enabled bits, `DONE` delayed by 10 cycles.
- Hold `GRAD_VALID`=1 continuously with changing `GRAD_MAG` during STREAM → `GRAD_READY`=0, later values ignored, next word accepted exactly at the cycle of `DONE`.
- Drive `INITn`=0 at bit 100 of a stream → all outputs 0 on the next edge, no `DONE`, `GRAD_READY`=1 after release, fresh stream bit-identical to a run from reset.
- `STREAM_LEN`=16 build → `DONE` at accept+17, exactly 16 `EN_OUT` cycles.

Source files
------------

// File: rtl/nn_sng_pkg.sv
// Shared types and LFSR helpers for the stochastic number generators.
// The tap table and the step function are used by nn_lfsr so every SNG
// in the datapath walks the same maximal-length sequences.
package nn_sng_pkg;

  // Gradient SNG control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } sng_state_e;

  // Fibonacci feedback masks (bit i set = tap on stage i) for
  // maximal-length LFSRs. Width 8 is x^8+x^6+x^5+x^4+1.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    logic [31:0] taps;
    case (w)
      32'd2:   taps = 32'h0000_0003;
      32'd3:   taps = 32'h0000_0006;
      32'd4:   taps = 32'h0000_000C;
      32'd5:   taps = 32'h0000_0014;
      32'd6:   taps = 32'h0000_0030;
      32'd7:   taps = 32'h0000_0060;
      32'd8:   taps = 32'h0000_00B8;
      32'd16:  taps = 32'h0000_D008;
      default: taps = 32'h0000_00B8;
    endcase
    return taps;
  endfunction

  // One Fibonacci step: shift toward the MSB, XOR of the tapped stages
  // enters at bit 0, result trimmed to the register width.
  function automatic logic [31:0] lfsr_next(input logic [31:0]   s,
                                            input logic [31:0]   taps,
                                            input int unsigned   w);
    logic [31:0] mask;
    logic        fb;
    mask = (32'h0000_0001 << w) - 32'h0000_0001;
    fb   = ^(s & taps);
    return ((s << 1) | {31'h0000_0000, fb}) & mask;
  endfunction

endpackage

// File: rtl/nn_lfsr.sv
// Loadable maximal-length Fibonacci LFSR shared by the stochastic number
// generators. Load has priority over step; reset returns to the seed.
module nn_lfsr
  import nn_sng_pkg::*;
#(
  parameter int          W    = 8,
  parameter logic [31:0] TAPS = 32'h0000_00B8
) (
  input  logic         CLK,
  input  logic         INITn,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state
);

  logic [W-1:0] state_r;
  logic [W-1:0] state_nxt_s;

  // Select reload, advance or hold for the next register value.
  always_comb begin
    state_nxt_s = state_r;
    if (load) begin
      state_nxt_s = seed;
    end else if (step) begin
      state_nxt_s = W'(lfsr_next(32'(state_r), TAPS, W));
    end else begin
      state_nxt_s = state_r;
    end
  end

  // LFSR state register with synchronous reset to the seed.
  always_ff @(posedge CLK) begin
    if (!INITn) begin
      state_r <= seed;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/nn_grad_sng.sv
// Signed stochastic gradient generator. Accepts one sign/magnitude word,
// then emits STREAM_LEN enabled bits whose 1-density encodes the magnitude,
// followed by a one-cycle DONE pulse. PAUSE freezes the stream losslessly.
module nn_grad_sng
  import nn_sng_pkg::*;
#(
  parameter int N          = 8,
  parameter int STREAM_LEN = (2 ** N) - 1,
  parameter int SEED       = 1
) (
  input  logic         CLK,
  input  logic         INITn,
  input  logic [N-1:0] GRAD_MAG,
  input  logic         GRAD_SIGN,
  input  logic         GRAD_VALID,
  output logic         GRAD_READY,
  input  logic         PAUSE,
  output logic         SS_OUT,
  output logic         SIGN_OUT,
  output logic         EN_OUT,
  output logic         DONE
);

  localparam int             CW       = $clog2(STREAM_LEN + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STREAM_LEN - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [N-1:0]   SEED_V   = N'(SEED);
  localparam logic [31:0]    TAPS     = lfsr_taps(N);

  sng_state_e     state_r, state_nxt_s;
  logic [CW-1:0]  cnt_r, cnt_nxt_s;
  logic [N-1:0]   mag_r, mag_nxt_s;
  logic           sign_r, sign_nxt_s;
  logic           ss_r, ss_nxt_s;
  logic           en_r, en_nxt_s;
  logic           done_r, done_nxt_s;
  logic           ready_s;
  logic           lfsr_load_s;
  logic           lfsr_step_s;
  logic [N-1:0]   lfsr_s;

  // Ready is decoded straight from the state so a word can be taken in
  // the same cycle DONE is presented.
  assign ready_s = (state_r == ST_IDLE) & INITn;

  nn_lfsr #(
    .W    (N),
    .TAPS (TAPS)
  ) u_lfsr (
    .CLK   (CLK),
    .INITn (INITn),
    .load  (lfsr_load_s),
    .step  (lfsr_step_s),
    .seed  (SEED_V),
    .state (lfsr_s)
  );

  // Next-state and next-output decode; outputs default to idle values.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    mag_nxt_s   = mag_r;
    sign_nxt_s  = sign_r;
    ss_nxt_s    = 1'b0;
    en_nxt_s    = 1'b0;
    done_nxt_s  = 1'b0;
    lfsr_load_s = 1'b0;
    lfsr_step_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (GRAD_VALID && ready_s) begin
          mag_nxt_s   = GRAD_MAG;
          sign_nxt_s  = GRAD_SIGN;
          cnt_nxt_s   = '0;
          lfsr_load_s = 1'b1;
          state_nxt_s = ST_STREAM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (!PAUSE) begin
          // Unsigned compare against a full-period LFSR gives exactly
          // mag_r ones over a 2^N-1 stream.
          ss_nxt_s    = (lfsr_s <= mag_r);
          en_nxt_s    = 1'b1;
          lfsr_step_s = 1'b1;
          cnt_nxt_s   = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_STREAM;
          end
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end
      ST_DONE: begin
        done_nxt_s  = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!INITn) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      mag_r   <= '0;
      sign_r  <= 1'b0;
      ss_r    <= 1'b0;
      en_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      mag_r   <= mag_nxt_s;
      sign_r  <= sign_nxt_s;
      ss_r    <= ss_nxt_s;
      en_r    <= en_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign GRAD_READY = ready_s;
  assign SS_OUT     = ss_r;
  assign SIGN_OUT   = sign_r;
  assign EN_OUT     = en_r;
  assign DONE       = done_r;

endmodule

// File: tb/tb_nn_grad_sng.sv
// Scoreboard bench for nn_grad_sng: drivers push expected streams when a
// word is accepted, monitors pop and check bits, counts and DONE timing.
module tb_nn_grad_sng;

  localparam int N     = 8;
  localparam int LEN_A = 255;
  localparam int LEN_B = 16;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         a_initn, a_valid, a_sign, a_pause;
  logic [N-1:0] a_mag;
  logic         a_ready, a_ss, a_sgo, a_en, a_done;
  logic         b_initn, b_valid, b_sign, b_pause;
  logic [N-1:0] b_mag;
  logic         b_ready, b_ss, b_sgo, b_en, b_done;

  nn_grad_sng #(.N(N), .STREAM_LEN(LEN_A), .SEED(1)) dut_a (
    .CLK(CLK), .INITn(a_initn), .GRAD_MAG(a_mag), .GRAD_SIGN(a_sign),
    .GRAD_VALID(a_valid), .GRAD_READY(a_ready), .PAUSE(a_pause),
    .SS_OUT(a_ss), .SIGN_OUT(a_sgo), .EN_OUT(a_en), .DONE(a_done));

  nn_grad_sng #(.N(N), .STREAM_LEN(LEN_B), .SEED(1)) dut_b (
    .CLK(CLK), .INITn(b_initn), .GRAD_MAG(b_mag), .GRAD_SIGN(b_sign),
    .GRAD_VALID(b_valid), .GRAD_READY(b_ready), .PAUSE(b_pause),
    .SS_OUT(b_ss), .SIGN_OUT(b_sgo), .EN_OUT(b_en), .DONE(b_done));

  typedef struct {
    logic [7:0] mag;
    logic       sign;
    int         t_acc;
    int         np;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  logic [7:0] seq [255];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic a_init_seen  = 1'b0;
  logic b_init_seen  = 1'b0;
  logic a_pause_seen = 1'b0;
  bit   b_finished   = 1'b0;

  // Reference m-sequence of x^8+x^6+x^5+x^4+1 starting from seed 1.
  initial begin
    logic [7:0] s;
    s = 8'd1;
    for (int k = 0; k < 255; k++) begin
      seq[k] = s;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected ones over a truncated stream: LFSR values not above the magnitude.
  function automatic int ones_short(input logic [7:0] m, input int len);
    int c;
    c = 0;
    for (int k = 0; k < len; k++) if (seq[k] <= m) c++;
    return c;
  endfunction

  // Cycle counter and edge-sampled copies of the inputs the DUTs saw.
  always @(posedge CLK) begin
    cyc          <= cyc + 1;
    a_init_seen  <= a_initn;
    b_init_seen  <= b_initn;
    a_pause_seen <= a_pause;
  end

  // Monitor A.
  ent_t cur_a;
  bit   a_active = 1'b0;
  bit   a_was_rst = 1'b0;
  int   a_nen, a_nones;
  always @(negedge CLK) begin
    if (!a_init_seen) begin
      chk("a_rst_ss", a_ss, 0);
      chk("a_rst_en", a_en, 0);
      chk("a_rst_done", a_done, 0);
      chk("a_rst_sign", a_sgo, 0);
      chk("a_rst_ready", a_ready, a_initn);
      qa.delete();
      a_active  = 1'b0;
      a_was_rst = 1'b1;
    end else begin
      if (a_was_rst) begin
        chk("a_ready_after_rst", a_ready, 1);
        a_was_rst = 1'b0;
      end
      chk("a_ss_gated", a_ss & ~a_en, 0);
      if (a_active && a_pause_seen && !a_done) chk("a_en_in_pause", a_en, 0);
      if (a_en) begin
        if (!a_active) begin
          if (qa.size() == 0) chk("a_unexpected_en", 1, 0);
          else begin
            cur_a = qa.pop_front();
            a_active = 1'b1; a_nen = 0; a_nones = 0;
          end
        end
        if (a_active) begin
          if (a_nen < 255) chk("a_bit", a_ss, 32'(seq[a_nen] <= cur_a.mag));
          else chk("a_overrun", a_nen, 254);
          chk("a_sign", a_sgo, cur_a.sign);
          chk("a_busy_ready", a_ready, 0);
          a_nen++;
          a_nones += int'(a_ss);
        end
      end
      if (a_done) begin
        if (!a_active) chk("a_unexpected_done", 1, 0);
        else begin
          chk("a_done_cycle", cyc, cur_a.t_acc + LEN_A + 1 + cur_a.np);
          chk("a_en_count", a_nen, LEN_A);
          chk("a_ones", a_nones, cur_a.mag);
          chk("a_done_sign", a_sgo, cur_a.sign);
          chk("a_done_ready", a_ready, 1);
          a_active = 1'b0;
        end
      end
    end
  end

  // Monitor B (short stream build).
  ent_t cur_b;
  bit   b_active = 1'b0;
  int   b_nen, b_nones;
  always @(negedge CLK) begin
    if (!b_init_seen) begin
      chk("b_rst_en", b_en, 0);
      chk("b_rst_done", b_done, 0);
      chk("b_rst_ss", b_ss, 0);
      qb.delete();
      b_active = 1'b0;
    end else begin
      if (b_en) begin
        if (!b_active) begin
          if (qb.size() == 0) chk("b_unexpected_en", 1, 0);
          else begin
            cur_b = qb.pop_front();
            b_active = 1'b1; b_nen = 0; b_nones = 0;
          end
        end
        if (b_active) begin
          if (b_nen < LEN_B) chk("b_bit", b_ss, 32'(seq[b_nen] <= cur_b.mag));
          else chk("b_overrun", b_nen, LEN_B - 1);
          chk("b_sign", b_sgo, cur_b.sign);
          b_nen++;
          b_nones += int'(b_ss);
        end
      end
      if (b_done) begin
        if (!b_active) chk("b_unexpected_done", 1, 0);
        else begin
          chk("b_done_cycle", cyc, cur_b.t_acc + LEN_B + 1);
          chk("b_en_count", b_nen, LEN_B);
          chk("b_ones", b_nones, ones_short(cur_b.mag, LEN_B));
          chk("b_done_ready", b_ready, 1);
          b_active = 1'b0;
        end
      end
    end
  end

  // Offer a word to A, push its expectation on acceptance, then apply an
  // optional pause of np cycles starting poff cycles into the stream.
  task automatic send_a(input logic [7:0] m, input logic s, input int np, input int poff);
    bit ok;
    @(posedge CLK); #1;
    a_mag = m; a_sign = s; a_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (a_ready) begin ok = 1'b1; break; end
      @(posedge CLK); #1;
    end
    if (!ok) begin
      chk("a_ready_timeout", 0, 1);
      a_valid = 1'b0;
      return;
    end
    qa.push_back('{mag: m, sign: s, t_acc: cyc + 1, np: np});
    @(posedge CLK); #1;
    a_valid = 1'b0;
    if (np > 0) begin
      repeat (poff) begin @(posedge CLK); #1; end
      a_pause = 1'b1;
      repeat (np) begin @(posedge CLK); #1; end
      a_pause = 1'b0;
    end
  endtask

  task automatic send_b(input logic [7:0] m, input logic s);
    bit ok;
    @(posedge CLK); #1;
    b_mag = m; b_sign = s; b_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (b_ready) begin ok = 1'b1; break; end
      @(posedge CLK); #1;
    end
    if (!ok) begin
      chk("b_ready_timeout", 0, 1);
      b_valid = 1'b0;
      return;
    end
    qb.push_back('{mag: m, sign: s, t_acc: cyc + 1, np: 0});
    @(posedge CLK); #1;
    b_valid = 1'b0;
  endtask

  // Short-stream DUT stimulus.
  initial begin
    b_initn = 1'b0; b_valid = 1'b0; b_mag = '0; b_sign = 1'b0; b_pause = 1'b0;
    repeat (3) @(posedge CLK);
    #1 b_initn = 1'b1;
    send_b(8'h40, 1'b0);
    send_b(8'($urandom), 1'b1);
    send_b(8'hFF, 1'b0);
    send_b(8'h00, 1'b1);
    b_finished = 1'b1;
  end

  // Main stimulus for the full-length DUT.
  initial begin
    int t1;
    bit ok;
    a_initn = 1'b0; a_valid = 1'b0; a_mag = '0; a_sign = 1'b0; a_pause = 1'b0;
    repeat (3) @(posedge CLK);
    #1 a_initn = 1'b1;

    send_a(8'h40, 1'b0, 0, 0);
    send_a(8'h00, 1'b0, 0, 0);
    send_a(8'hFF, 1'b1, 0, 0);
    send_a(8'h80, 1'b0, 10, 60);

    // Valid held high with a changing word during the stream.
    @(posedge CLK); #1;
    a_mag = 8'h10; a_sign = 1'b0; a_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (a_ready) begin ok = 1'b1; break; end
      @(posedge CLK); #1;
    end
    t1 = cyc + 1;
    if (ok) qa.push_back('{mag: 8'h10, sign: 1'b0, t_acc: t1, np: 0});
    else chk("a_hold_first_timeout", 0, 1);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge CLK); #1;
      if (a_ready) begin ok = 1'b1; break; end
      a_mag = 8'($urandom); a_sign = 1'($urandom);
    end
    if (ok) begin
      chk("a_accept_at_done", cyc + 1, t1 + LEN_A + 2);
      qa.push_back('{mag: a_mag, sign: a_sign, t_acc: cyc + 1, np: 0});
    end else chk("a_hold_second_timeout", 0, 1);
    @(posedge CLK); #1;
    a_valid = 1'b0;

    // Reset at bit 100 of a stream, then the same word again from scratch.
    send_a(8'h5A, 1'b1, 0, 0);
    repeat (100) begin @(posedge CLK); #1; end
    a_initn = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    a_initn = 1'b1;
    send_a(8'h5A, 1'b1, 0, 0);

    for (int r = 0; r < 5; r++) begin
      send_a(8'($urandom), 1'($urandom), int'($urandom_range(0, 4)),
             int'($urandom_range(1, 200)));
    end

    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (qa.size() == 0 && !a_active && qb.size() == 0 && !b_active && b_finished) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK);
    end
    chk("drain", ok, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
